pc_sequencer: RTL and testbench

Registered program-counter unit that generalises the combinational next-PC mux into a clocked fetch sequencer. Holds the PC and issues fetch requests over a valid/ready handshake. Resolves all branch kinds from the execute stage (B, BL, CBZ, CBNZ, B.cond, BR, RET) and keeps a parametrised return-address stack (RAS). Sits between the control/execute stage and instruction memory.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/ras_stack.sv | 59 +++++
 rtl/pc_sequencer.sv | 136 +++++++++++++
 tb/tb_pc_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch sequencer: branch-kind encoding and
// instruction-size helper.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      BR_NONE  = 3'd0,
      BR_B     = 3'd1,
      BR_BL    = 3'd2,
      BR_CBZ   = 3'd3,
      BR_CBNZ  = 3'd4,
      BR_BCOND = 3'd5,
      BR_BR    = 3'd6,
      BR_RET   = 3'd7
   } br_type_e;

   // Instruction size in bytes for a given log2 size.
   function automatic int unsigned instr_bytes(input int unsigned shift);
      return 32'd1 << shift;
   endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular write pointer plus saturating count.
// A push into a full stack silently overwrites the oldest entry.
module ras_stack #(
   parameter int PC_W      = 64,
   parameter int RAS_DEPTH = 4
) (
   input  logic            CLK,
   input  logic            resetl,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] push_data,
   output logic [PC_W-1:0] top,
   output logic            empty,
   output logic            full
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam logic [PTR_W-1:0] P_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]   C_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(RAS_DEPTH);

   logic [PC_W-1:0]  mem_q [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;   // next slot to write
   logic [PTR_W:0]   cnt_q, cnt_d;   // live entries, saturates at depth

   assign top   = mem_q[ptr_q - P_ONE];
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == DEPTH_C);

   // Pointer/count update; a pop on an empty stack is ignored.
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push) begin
         ptr_d = ptr_q + P_ONE;
         if (cnt_q != DEPTH_C) cnt_d = cnt_q + C_ONE;
      end else if (pop && (cnt_q != '0)) begin
         ptr_d = ptr_q - P_ONE;
         cnt_d = cnt_q - C_ONE;
      end
   end

   // Pointer and count registers.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage; contents are only meaningful while counted live.
   always_ff @(posedge CLK) begin
      if (push) mem_q[ptr_q] <= push_data;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch sequencer: holds the PC, issues fetch requests over
// valid/ready, resolves execute-stage branches and tracks returns in a RAS.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int                PC_W        = 64,
   parameter int                INSTR_SHIFT = 2,
   parameter logic [PC_W-1:0]   RESET_PC    = '0,
   parameter int                RAS_DEPTH   = 4
) (
   input  logic            CLK,
   input  logic            resetl,
   input  logic            stall,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic [PC_W-1:0] currentpc,
   input  logic            br_valid,
   input  logic [2:0]      br_type,
   input  logic [PC_W-1:0] br_pc,
   input  logic [PC_W-1:0] br_imm,
   input  logic            br_zero,
   input  logic            br_cond,
   input  logic [PC_W-1:0] br_reg,
   output logic [PC_W-1:0] link_addr,
   output logic            flush,
   output logic            misalign,
   output logic            ras_empty,
   output logic            ras_full
);

   localparam logic [PC_W-1:0] STEP     = PC_W'(instr_bytes(INSTR_SHIFT));
   localparam logic [PC_W-1:0] LOW_MASK = STEP - PC_W'(1);

   logic [PC_W-1:0] pc_q, pc_d;
   logic            fetch_valid_q, fetch_valid_d;
   logic            init_q, init_d;        // set after the first edge out of reset
   logic            flush_q, flush_d;
   logic            misalign_q, misalign_d;

   logic            taken;
   logic            from_reg;              // target came from br_reg
   logic [PC_W-1:0] tgt;
   logic            ras_push, ras_pop;
   logic [PC_W-1:0] ras_top;

   assign link_addr   = br_pc + STEP;
   assign currentpc   = pc_q;
   assign fetch_valid = fetch_valid_q;
   assign flush       = flush_q;
   assign misalign    = misalign_q;

   ras_stack #(
      .PC_W      (PC_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .CLK       (CLK),
      .resetl    (resetl),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (link_addr),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

   // Branch resolution: taken decision, target select and RAS control.
   always_comb begin
      taken    = 1'b0;
      from_reg = 1'b0;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      tgt      = br_pc + (br_imm << INSTR_SHIFT);
      if (br_valid) begin
         case (br_type_e'(br_type))
            BR_B:     taken = 1'b1;
            BR_BL: begin
               taken    = 1'b1;
               ras_push = 1'b1;
            end
            BR_CBZ:   taken = br_zero;
            BR_CBNZ:  taken = !br_zero;
            BR_BCOND: taken = br_cond;
            BR_BR: begin
               taken    = 1'b1;
               from_reg = 1'b1;
               tgt      = br_reg;
            end
            BR_RET: begin
               taken = 1'b1;
               if (!ras_empty) begin
                  ras_pop = 1'b1;
                  tgt     = ras_top;
               end else begin
                  from_reg = 1'b1;
                  tgt      = br_reg;
               end
            end
            default:  taken = 1'b0;
         endcase
      end
   end

   // Next PC: taken branch beats stall, stall beats sequential advance.
   always_comb begin
      pc_d          = pc_q;
      flush_d       = 1'b0;
      misalign_d    = 1'b0;
      init_d        = 1'b1;
      fetch_valid_d = init_q ? !stall : 1'b1;
      if (taken) begin
         pc_d       = tgt & ~LOW_MASK;
         flush_d    = 1'b1;
         misalign_d = from_reg && ((tgt & LOW_MASK) != '0);
      end else if (fetch_valid_q && fetch_ready && !stall) begin
         pc_d = pc_q + STEP;
      end
   end

   // Sequencer state; reset drops any redirect in flight.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         pc_q          <= RESET_PC;
         fetch_valid_q <= 1'b0;
         init_q        <= 1'b0;
         flush_q       <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         fetch_valid_q <= fetch_valid_d;
         init_q        <= init_d;
         flush_q       <= flush_d;
         misalign_q    <= misalign_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, advance, conditional branches,
// stall, RAS overflow/underflow, misaligned register target, wrap, mid-op reset.
module tb_pc_sequencer;

   localparam int PC_W = 64;

   logic            CLK = 1'b0;
   logic            resetl, stall, fetch_ready, br_valid, br_zero, br_cond;
   logic [2:0]      br_type;
   logic [PC_W-1:0] br_pc, br_imm, br_reg;
   logic            fetch_valid, flush, misalign, ras_empty, ras_full;
   logic [PC_W-1:0] currentpc, link_addr;

   int total = 0;
   int bad   = 0;

   pc_sequencer #(
      .PC_W        (PC_W),
      .INSTR_SHIFT (2),
      .RESET_PC    (64'h100),
      .RAS_DEPTH   (4)
   ) dut (
      .CLK         (CLK),
      .resetl      (resetl),
      .stall       (stall),
      .fetch_valid (fetch_valid),
      .fetch_ready (fetch_ready),
      .currentpc   (currentpc),
      .br_valid    (br_valid),
      .br_type     (br_type),
      .br_pc       (br_pc),
      .br_imm      (br_imm),
      .br_zero     (br_zero),
      .br_cond     (br_cond),
      .br_reg      (br_reg),
      .link_addr   (link_addr),
      .flush       (flush),
      .misalign    (misalign),
      .ras_empty   (ras_empty),
      .ras_full    (ras_full)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic branch(input logic [2:0] t, input logic [63:0] pc,
                         input logic [63:0] imm, input logic [63:0] rg);
      br_valid = 1'b1;
      br_type  = t;
      br_pc    = pc;
      br_imm   = imm;
      br_reg   = rg;
   endtask

   initial begin
      resetl = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
      br_valid = 1'b0; br_type = 3'd0; br_zero = 1'b0; br_cond = 1'b0;
      br_pc = '0; br_imm = '0; br_reg = '0;

      // 1. reset and sequential advance
      tick(); tick();
      chk("rst_pc", currentpc, 64'h100);
      chk("rst_fv", fetch_valid, 1'b0);
      chk("rst_flush", flush, 1'b0);
      chk("rst_ras_empty", ras_empty, 1'b1);
      chk("rst_ras_full", ras_full, 1'b0);
      resetl = 1'b1;
      tick();
      chk("first_fv", fetch_valid, 1'b1);
      chk("first_pc", currentpc, 64'h100);
      tick(); chk("adv_104", currentpc, 64'h104);
      tick(); chk("adv_108", currentpc, 64'h108);
      tick(); chk("adv_10c", currentpc, 64'h10C);
      chk("adv_flush", flush, 1'b0);

      // 2. CBZ taken and not taken
      branch(3'd3, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF - 64'd3, 64'h0);
      br_zero = 1'b1;
      #1 chk("link_addr", link_addr, 64'h204);
      tick();
      chk("cbz_pc", currentpc, 64'h1F0);
      chk("cbz_flush", flush, 1'b1);
      br_valid = 1'b0;
      tick();
      chk("cbz_flush_end", flush, 1'b0);
      chk("cbz_after", currentpc, 64'h1F4);
      branch(3'd3, 64'h200, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
      br_zero = 1'b0;
      tick();
      chk("cbz_nt_pc", currentpc, 64'h1F8);
      chk("cbz_nt_flush", flush, 1'b0);

      // 3. stall, then CBNZ redirect during stall
      branch(3'd6, 64'h0, 64'h0, 64'h40);
      tick();
      chk("br40", currentpc, 64'h40);
      br_valid = 1'b0;
      stall = 1'b1;
      tick();
      chk("stall1_pc", currentpc, 64'h40);
      chk("stall1_fv", fetch_valid, 1'b0);
      tick();
      chk("stall2_pc", currentpc, 64'h40);
      branch(3'd4, 64'h30, 64'h8, 64'h0);
      br_zero = 1'b0;
      tick();
      chk("cbnz_stall_pc", currentpc, 64'h50);
      chk("cbnz_stall_flush", flush, 1'b1);
      br_valid = 1'b0;
      stall = 1'b0;
      tick();
      chk("unstall_fv", fetch_valid, 1'b1);
      chk("unstall_pc", currentpc, 64'h50);
      tick();
      chk("unstall_adv", currentpc, 64'h54);

      // 4. RAS overflow then drain
      for (int i = 0; i < 5; i++) begin
         branch(3'd2, 64'(i * 16), 64'h0, 64'h0);
         tick();
         chk("bl_pc", currentpc, 64'(i * 16));
         chk("bl_empty", ras_empty, 1'b0);
         chk("bl_full", ras_full, (i >= 3) ? 1'b1 : 1'b0);
      end
      branch(3'd7, 64'h0, 64'h0, 64'h800);
      tick(); chk("ret1", currentpc, 64'h44);
      chk("ret1_full", ras_full, 1'b0);
      tick(); chk("ret2", currentpc, 64'h34);
      tick(); chk("ret3", currentpc, 64'h24);
      tick(); chk("ret4", currentpc, 64'h14);
      chk("ret_empty", ras_empty, 1'b1);
      tick();
      chk("ret5_fallback", currentpc, 64'h800);
      chk("ret5_flush", flush, 1'b1);
      chk("ret5_misalign", misalign, 1'b0);
      chk("ret5_empty", ras_empty, 1'b1);

      // 5. misaligned register target
      branch(3'd6, 64'h0, 64'h0, 64'h1003);
      tick();
      chk("mis_pc", currentpc, 64'h1000);
      chk("mis_pulse", misalign, 1'b1);
      chk("mis_flush", flush, 1'b1);
      br_valid = 1'b0;
      tick();
      chk("mis_end", misalign, 1'b0);
      chk("mis_flush_end", flush, 1'b0);
      chk("mis_adv", currentpc, 64'h1004);

      // 6. wrap at top of address space, then reset mid-branch
      branch(3'd6, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      chk("top_pc", currentpc, 64'hFFFF_FFFF_FFFF_FFFC);
      br_valid = 1'b0;
      tick();
      chk("wrap_pc", currentpc, 64'h0);
      branch(3'd2, 64'h300, 64'h10, 64'h0);
      tick();
      chk("bl2_pc", currentpc, 64'h340);
      chk("bl2_ras", ras_empty, 1'b0);
      branch(3'd6, 64'h0, 64'h0, 64'h2000);
      #1 resetl = 1'b0;
      #1;
      chk("arst_pc", currentpc, 64'h100);
      chk("arst_flush", flush, 1'b0);
      chk("arst_ras", ras_empty, 1'b1);
      chk("arst_fv", fetch_valid, 1'b0);
      tick();
      chk("arst_hold_pc", currentpc, 64'h100);
      br_valid = 1'b0;
      resetl = 1'b1;
      tick();
      chk("rel_pc", currentpc, 64'h100);
      chk("rel_fv", fetch_valid, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
